sram_arb_ctrl: RTL and testbench
================================

// Module: sram_arb_ctrl
// PURPOSE
//  Sequences the external 32-bit asynchronous SRAM (22-bit word address) for the FPGA build and
//  shares it between two requesters: port 0 (CPU bus) and port 1 (DMA). Generates ce_n/oe_n/we_n/
//  dm_n/zz_n timing from a single clock, drives the split data bus (top level builds the tristate),
//  and puts the SRAM into sleep (zz_n low) after a programmable idle period.
// PARAMETERS
//  RD_CYCLES    2   cycles ce_n/oe_n held low before read data is captured (>=1)
//  WR_CYCLES    2   we_n low pulse width in cycles (>=1)
//  SLEEP_IDLE   64  consecutive idle cycles before zz_n asserts; 0 disables sleep
//  WAKE_CYCLES  4   cycles zz_n held high after sleep before any access (>=1)
// PORTS
//  clk12        in   1   clock
//  reset        in   1   asynchronous, active-high reset
//  mN_req       in   1   N=0,1: access request, held until mN_ack
//  mN_we        in   1   1=write, 0=read; stable while req high
//  mN_adr       in   22  word address
//  mN_wdata     in   32  write data
//  mN_be        in   4   byte enables (bit i = byte i)
//  mN_ack       out  1   one-cycle completion pulse
//  mN_rdata     out  32  read data, valid in ack cycle, held until next read ack on that port
//  sram_adr     out  22  SRAM address
//  sram_ce_n    out  1   chip enable, active low
//  sram_oe_n    out  1   output enable, active low
//  sram_we_n    out  1   write enable, active low
//  sram_zz_n    out  1   sleep, active low
//  sram_dm_n    out  4   byte masks, active low
//  sram_d_o     out  32  data to SRAM
//  sram_d_oe    out  1   1 = FPGA drives sram_d
//  sram_d_i     in   32  data from SRAM
//  busy         out  1   high in any state other than IDLE/SLEEP
// BEHAVIOUR
//  Reset (async): ce_n=oe_n=we_n=zz_n=1, dm_n=4'hF, d_oe=0, adr=0, d_o=0, acks=0, rdata=0,
//   busy=0, state=IDLE, idle counter=0, last_grant=1 (port 0 wins first contention).
//  States: IDLE, RD, WR_SETUP, WR_PULSE, WR_HOLD, ACK, SLEEP, WAKE. All outputs registered.
//  IDLE: arbitration only here. One req -> grant it. Both -> grant port != last_grant; update
//   last_grant. Latch adr/we/wdata/be of winner. we=0 -> RD, we=1 -> WR_SETUP.
//  RD: ce_n=0, oe_n=0, dm_n=0, d_oe=0, for RD_CYCLES cycles; sram_d_i captured on last RD cycle.
//  WR_SETUP (1 cyc): ce_n=0, we_n=1, oe_n=1, d_oe=1, d_o=wdata, dm_n=~be.
//  WR_PULSE (WR_CYCLES): as setup but we_n=0. WR_HOLD (1 cyc): we_n=1, ce_n=0, data still driven
//   (we_n rises while ce_n low and data stable).
//  ACK (1 cyc): ce_n=oe_n=we_n=1, d_oe=0, dm_n=4'hF, granted mN_ack=1, rdata updated on reads.
//   Next state IDLE; guarantees >=1 deselect cycle between accesses.
//  Latency (req first sampled high in IDLE at cycle 0): read ack cycle RD_CYCLES+1;
//   write ack cycle WR_CYCLES+3. Back-to-back same port: next req sampled in cycle after ACK.
//  Requester protocol: req/we/adr/wdata/be stable from assertion to ack; req dropped in cycle after
//   ack unless another access follows. Dropping req before ack is illegal (access still completes).
//  Sleep: idle counter increments each IDLE cycle with no req, clears on leaving IDLE or on req.
//   Counter reaching SLEEP_IDLE -> SLEEP (zz_n=0). In SLEEP any req -> WAKE (zz_n=1) for
//   WAKE_CYCLES, then IDLE (arbitration). Sleep adds WAKE_CYCLES+1 cycles to latency.
//   Counter saturates; SLEEP_IDLE=0 never enters SLEEP.
//  Reset mid-access: strobes deassert immediately, no ack issued; word under write is undefined.
//  Never: we_n and oe_n low together; d_oe=1 while oe_n=0; zz_n=0 while ce_n=0.
// TESTING
//  1 mem[22'h000123]=32'hDEADBEEF; m0 read 0x000123, RD_CYCLES=2 -> m0_ack in cycle 3,
//    m0_rdata=DEADBEEF, oe_n low exactly cycles 1-2.
//  2 m1 write 0x3FFFFF, 32'hA5A55A5A, be=4'hF -> one we_n low pulse of 2 cycles, ce_n low at we_n
//    rise, m1_ack cycle 5; m0 readback returns A5A55A5A.
//  3 m0 and m1 request same cycle, repeated 4 times -> grants alternate 0,1,0,1; no lost acks.
//  4 Write be=4'b0101 over 32'hFFFFFFFF -> dm_n=4'b1010 during WR_*; readback bytes 0,2 = FF only.
//  5 SLEEP_IDLE=16: no req 16 cycles -> zz_n=0; m0 read -> zz_n=1, ack delayed by WAKE_CYCLES+1.
//  6 Assert reset during WR_PULSE -> ce_n/we_n high same instant, no ack; subsequent read correct.

Source files
------------

// File: rtl/sram_arb_ctrl.sv
// sram_arb_ctrl: two-port arbiter and timing sequencer for a 32-bit asynchronous
// SRAM with a 22-bit word address. Port 0 (CPU) and port 1 (DMA) share the device.
// Contention is resolved round-robin. The controller drives ce_n/oe_n/we_n/dm_n/zz_n
// and a split data bus, and puts the SRAM to sleep after a programmable idle period.
// Every output comes straight from a flop.
module sram_arb_ctrl #(
    parameter int RD_CYCLES   = 2,
    parameter int WR_CYCLES   = 2,
    parameter int SLEEP_IDLE  = 64,
    parameter int WAKE_CYCLES = 4
) (
    input  logic        clk12,
    input  logic        reset,

    input  logic        m0_req,
    input  logic        m0_we,
    input  logic [21:0] m0_adr,
    input  logic [31:0] m0_wdata,
    input  logic [3:0]  m0_be,
    output logic        m0_ack,
    output logic [31:0] m0_rdata,

    input  logic        m1_req,
    input  logic        m1_we,
    input  logic [21:0] m1_adr,
    input  logic [31:0] m1_wdata,
    input  logic [3:0]  m1_be,
    output logic        m1_ack,
    output logic [31:0] m1_rdata,

    output logic [21:0] sram_adr,
    output logic        sram_ce_n,
    output logic        sram_oe_n,
    output logic        sram_we_n,
    output logic        sram_zz_n,
    output logic [3:0]  sram_dm_n,
    output logic [31:0] sram_d_o,
    output logic        sram_d_oe,
    input  logic [31:0] sram_d_i,

    output logic        busy
);

    // Phase counter is shared by RD, WR_PULSE and WAKE; 16 bits covers any sane timing.
    localparam int PH_W = 16;
    localparam logic [PH_W-1:0] PH_ONE    = PH_W'(1);
    localparam logic [PH_W-1:0] RD_LAST   = PH_W'(RD_CYCLES - 1);
    localparam logic [PH_W-1:0] WR_LAST   = PH_W'(WR_CYCLES - 1);
    localparam logic [PH_W-1:0] WAKE_LAST = PH_W'(WAKE_CYCLES - 1);

    // The idle counter only has to reach SLEEP_IDLE; it saturates at all-ones.
    localparam int IDLE_W = (SLEEP_IDLE < 2) ? 1 : $clog2(SLEEP_IDLE + 1);
    localparam logic [IDLE_W-1:0] IDLE_ONE   = IDLE_W'(1);
    localparam logic [IDLE_W-1:0] IDLE_MAX   = '1;
    localparam logic [IDLE_W-1:0] SLEEP_TRIG = IDLE_W'(SLEEP_IDLE - 1);
    localparam bit                SLEEP_EN   = (SLEEP_IDLE != 0);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_WR_SETUP,
        S_WR_PULSE,
        S_WR_HOLD,
        S_ACK,
        S_SLEEP,
        S_WAKE
    } state_t;

    state_t              state_reg, state_next;
    logic [PH_W-1:0]     ph_cnt_reg, ph_cnt_next;
    logic [IDLE_W-1:0]   idle_cnt_reg, idle_cnt_next;
    logic                last_grant_reg, last_grant_next;
    logic                grant_reg, grant_next;
    logic                lat_we_reg, lat_we_next;
    logic [21:0]         lat_adr_reg, lat_adr_next;
    logic [31:0]         lat_wdata_reg, lat_wdata_next;
    logic [3:0]          lat_be_reg, lat_be_next;
    logic                pick;

    // Next values of the registered outputs.
    logic [21:0]         adr_next;
    logic                ce_n_next, oe_n_next, we_n_next, zz_n_next;
    logic [3:0]          dm_n_next;
    logic [31:0]         d_o_next;
    logic                d_oe_next;
    logic                ack0_next, ack1_next;
    logic [31:0]         rdata0_next, rdata1_next;
    logic                busy_next;

    // State register: FSM state, counters, latched request and all outputs.
    // Reset forces every strobe inactive at once, so an access in flight is abandoned.
    always_ff @(posedge clk12 or posedge reset) begin
        if (reset) begin
            state_reg      <= S_IDLE;
            ph_cnt_reg     <= '0;
            idle_cnt_reg   <= '0;
            last_grant_reg <= 1'b1;
            grant_reg      <= 1'b0;
            lat_we_reg     <= 1'b0;
            lat_adr_reg    <= '0;
            lat_wdata_reg  <= '0;
            lat_be_reg     <= '0;
            sram_adr       <= '0;
            sram_ce_n      <= 1'b1;
            sram_oe_n      <= 1'b1;
            sram_we_n      <= 1'b1;
            sram_zz_n      <= 1'b1;
            sram_dm_n      <= 4'hF;
            sram_d_o       <= '0;
            sram_d_oe      <= 1'b0;
            m0_ack         <= 1'b0;
            m1_ack         <= 1'b0;
            m0_rdata       <= '0;
            m1_rdata       <= '0;
            busy           <= 1'b0;
        end else begin
            state_reg      <= state_next;
            ph_cnt_reg     <= ph_cnt_next;
            idle_cnt_reg   <= idle_cnt_next;
            last_grant_reg <= last_grant_next;
            grant_reg      <= grant_next;
            lat_we_reg     <= lat_we_next;
            lat_adr_reg    <= lat_adr_next;
            lat_wdata_reg  <= lat_wdata_next;
            lat_be_reg     <= lat_be_next;
            sram_adr       <= adr_next;
            sram_ce_n      <= ce_n_next;
            sram_oe_n      <= oe_n_next;
            sram_we_n      <= we_n_next;
            sram_zz_n      <= zz_n_next;
            sram_dm_n      <= dm_n_next;
            sram_d_o       <= d_o_next;
            sram_d_oe      <= d_oe_next;
            m0_ack         <= ack0_next;
            m1_ack         <= ack1_next;
            m0_rdata       <= rdata0_next;
            m1_rdata       <= rdata1_next;
            busy           <= busy_next;
        end
    end

    // Next-state logic: arbitration in IDLE, phase timing, idle/sleep counting.
    always_comb begin
        state_next      = state_reg;
        ph_cnt_next     = ph_cnt_reg;
        idle_cnt_next   = idle_cnt_reg;
        last_grant_next = last_grant_reg;
        grant_next      = grant_reg;
        lat_we_next     = lat_we_reg;
        lat_adr_next    = lat_adr_reg;
        lat_wdata_next  = lat_wdata_reg;
        lat_be_next     = lat_be_reg;
        pick            = 1'b0;

        case (state_reg)
            S_IDLE: begin
                if (m0_req || m1_req) begin
                    // Round-robin only matters under contention; a lone requester just wins.
                    if (m0_req && m1_req) begin
                        pick            = ~last_grant_reg;
                        last_grant_next = pick;
                    end else begin
                        pick = m1_req;
                    end
                    grant_next     = pick;
                    lat_we_next    = pick ? m1_we    : m0_we;
                    lat_adr_next   = pick ? m1_adr   : m0_adr;
                    lat_wdata_next = pick ? m1_wdata : m0_wdata;
                    lat_be_next    = pick ? m1_be    : m0_be;
                    idle_cnt_next  = '0;
                    ph_cnt_next    = '0;
                    state_next     = (pick ? m1_we : m0_we) ? S_WR_SETUP : S_RD;
                end else if (SLEEP_EN && (idle_cnt_reg == SLEEP_TRIG)) begin
                    idle_cnt_next = '0;
                    state_next    = S_SLEEP;
                end else if (idle_cnt_reg != IDLE_MAX) begin
                    idle_cnt_next = idle_cnt_reg + IDLE_ONE;
                end
            end
            S_RD: begin
                if (ph_cnt_reg == RD_LAST) begin
                    state_next = S_ACK;
                end else begin
                    ph_cnt_next = ph_cnt_reg + PH_ONE;
                end
            end
            S_WR_SETUP: begin
                ph_cnt_next = '0;
                state_next  = S_WR_PULSE;
            end
            S_WR_PULSE: begin
                if (ph_cnt_reg == WR_LAST) begin
                    state_next = S_WR_HOLD;
                end else begin
                    ph_cnt_next = ph_cnt_reg + PH_ONE;
                end
            end
            S_WR_HOLD: begin
                state_next = S_ACK;
            end
            S_ACK: begin
                // Always return through IDLE so the chip sees a deselect cycle between accesses.
                idle_cnt_next = '0;
                state_next    = S_IDLE;
            end
            S_SLEEP: begin
                if (m0_req || m1_req) begin
                    ph_cnt_next = '0;
                    state_next  = S_WAKE;
                end
            end
            S_WAKE: begin
                if (ph_cnt_reg == WAKE_LAST) begin
                    state_next = S_IDLE;
                end else begin
                    ph_cnt_next = ph_cnt_reg + PH_ONE;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Output logic: decode the upcoming state so the strobes are registered and glitch-free.
    always_comb begin
        adr_next    = sram_adr;
        ce_n_next   = 1'b1;
        oe_n_next   = 1'b1;
        we_n_next   = 1'b1;
        zz_n_next   = 1'b1;
        dm_n_next   = 4'hF;
        d_o_next    = sram_d_o;
        d_oe_next   = 1'b0;
        ack0_next   = 1'b0;
        ack1_next   = 1'b0;
        rdata0_next = m0_rdata;
        rdata1_next = m1_rdata;
        busy_next   = 1'b1;

        case (state_next)
            S_IDLE: begin
                busy_next = 1'b0;
            end
            S_SLEEP: begin
                busy_next = 1'b0;
                zz_n_next = 1'b0;
            end
            S_RD: begin
                adr_next  = lat_adr_next;
                ce_n_next = 1'b0;
                oe_n_next = 1'b0;
                dm_n_next = 4'h0;
            end
            S_WR_SETUP, S_WR_HOLD: begin
                adr_next  = lat_adr_next;
                ce_n_next = 1'b0;
                d_oe_next = 1'b1;
                d_o_next  = lat_wdata_next;
                dm_n_next = ~lat_be_next;
            end
            S_WR_PULSE: begin
                adr_next  = lat_adr_next;
                ce_n_next = 1'b0;
                we_n_next = 1'b0;
                d_oe_next = 1'b1;
                d_o_next  = lat_wdata_next;
                dm_n_next = ~lat_be_next;
            end
            S_ACK: begin
                // Entering ACK from RD is the last cycle oe_n is low, so sram_d_i is sampled here.
                ack0_next = ~grant_next;
                ack1_next = grant_next;
                if (!lat_we_next) begin
                    if (grant_next) begin
                        rdata1_next = sram_d_i;
                    end else begin
                        rdata0_next = sram_d_i;
                    end
                end
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_sram_arb_ctrl.sv
// Directed testbench for sram_arb_ctrl with a behavioural SRAM model (256 words,
// indexed by the low address byte). Outputs are sampled on the falling clock edge.
module tb_sram_arb_ctrl;

    logic        clk12;
    logic        reset;
    logic        m0_req, m0_we, m1_req, m1_we;
    logic [21:0] m0_adr, m1_adr;
    logic [31:0] m0_wdata, m1_wdata;
    logic [3:0]  m0_be, m1_be;
    logic        m0_ack, m1_ack;
    logic [31:0] m0_rdata, m1_rdata;
    logic [21:0] sram_adr;
    logic        sram_ce_n, sram_oe_n, sram_we_n, sram_zz_n;
    logic [3:0]  sram_dm_n;
    logic [31:0] sram_d_o;
    logic        sram_d_oe;
    logic [31:0] sram_d_i;
    logic        busy;

    int n_assert = 0;
    int n_fail   = 0;

    logic [31:0] mem [0:255];

    sram_arb_ctrl #(
        .RD_CYCLES  (2),
        .WR_CYCLES  (2),
        .SLEEP_IDLE (16),
        .WAKE_CYCLES(4)
    ) dut (
        .clk12    (clk12),
        .reset    (reset),
        .m0_req   (m0_req),
        .m0_we    (m0_we),
        .m0_adr   (m0_adr),
        .m0_wdata (m0_wdata),
        .m0_be    (m0_be),
        .m0_ack   (m0_ack),
        .m0_rdata (m0_rdata),
        .m1_req   (m1_req),
        .m1_we    (m1_we),
        .m1_adr   (m1_adr),
        .m1_wdata (m1_wdata),
        .m1_be    (m1_be),
        .m1_ack   (m1_ack),
        .m1_rdata (m1_rdata),
        .sram_adr (sram_adr),
        .sram_ce_n(sram_ce_n),
        .sram_oe_n(sram_oe_n),
        .sram_we_n(sram_we_n),
        .sram_zz_n(sram_zz_n),
        .sram_dm_n(sram_dm_n),
        .sram_d_o (sram_d_o),
        .sram_d_oe(sram_d_oe),
        .sram_d_i (sram_d_i),
        .busy     (busy)
    );

    initial clk12 = 1'b0;
    always #5 clk12 = ~clk12;

    // SRAM model: drives data while selected and output-enabled, otherwise a marker value.
    assign sram_d_i = (!sram_ce_n && !sram_oe_n) ? mem[sram_adr[7:0]] : 32'h0BAD0BAD;

    // SRAM model: byte-masked write on each clock with ce_n and we_n low.
    always @(posedge clk12) begin
        if (!sram_ce_n && !sram_we_n) begin
            for (int b = 0; b < 4; b++) begin
                if (!sram_dm_n[b]) begin
                    mem[sram_adr[7:0]][8*b +: 8] <= sram_d_oe ? sram_d_o[8*b +: 8] : 8'h5A;
                end
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Pin-level rules that must hold on every cycle.
    always @(negedge clk12) begin
        check("inv_we_oe", {31'b0, (!sram_we_n && !sram_oe_n)}, 32'd0);
        check("inv_doe_oe", {31'b0, (sram_d_oe && !sram_oe_n)}, 32'd0);
        check("inv_zz_ce", {31'b0, (!sram_zz_n && !sram_ce_n)}, 32'd0);
    end

    // One access on a port. Waits one falling edge first (the IDLE/SLEEP cycle in which
    // the request is presented), then checks pins, latency and the single-cycle ack.
    task automatic do_access(input int port, input logic we, input logic [21:0] adr,
                             input logic [31:0] wdata, input logic [3:0] be,
                             input int off, input string tag);
        int lat;
        int base;
        logic ack;
        base = we ? 5 : 3;
        @(negedge clk12);
        check({tag, "_ack_idle"}, {30'b0, m1_ack, m0_ack}, 32'd0);
        if (port == 0) begin
            m0_req = 1'b1; m0_we = we; m0_adr = adr; m0_wdata = wdata; m0_be = be;
        end else begin
            m1_req = 1'b1; m1_we = we; m1_adr = adr; m1_wdata = wdata; m1_be = be;
        end
        lat = 0;
        for (int n = 1; n <= 40 && lat == 0; n++) begin
            @(negedge clk12);
            ack = (port == 0) ? m0_ack : m1_ack;
            if (ack) lat = n;
            check({tag, "_zz_n"}, {31'b0, sram_zz_n}, 32'd1);
            if (n > off && n <= off + base - 1) begin
                check({tag, "_adr"}, {10'b0, sram_adr}, {10'b0, adr});
                check({tag, "_dm_n"}, {28'b0, sram_dm_n}, we ? {28'b0, ~be} : 32'd0);
            end
        end
        check({tag, "_lat"}, lat, base + off);
        $display("access %s port=%0d we=%0d adr=%h latency=%0d", tag, port, we, adr, lat);
        if (port == 0) m0_req = 1'b0; else m1_req = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int first;
        int second;
        int n;

        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        mem[8'h23] = 32'hDEADBEEF;
        mem[8'h10] = 32'h11111111;
        mem[8'h11] = 32'h22222222;
        reset = 1'b1;
        m0_req = 0; m0_we = 0; m0_adr = '0; m0_wdata = '0; m0_be = '0;
        m1_req = 0; m1_we = 0; m1_adr = '0; m1_wdata = '0; m1_be = '0;
        repeat (3) @(negedge clk12);

        // Reset state
        check("rst_ce_n", {31'b0, sram_ce_n}, 32'd1);
        check("rst_oe_n", {31'b0, sram_oe_n}, 32'd1);
        check("rst_we_n", {31'b0, sram_we_n}, 32'd1);
        check("rst_zz_n", {31'b0, sram_zz_n}, 32'd1);
        check("rst_dm_n", {28'b0, sram_dm_n}, 32'hF);
        check("rst_d_oe", {31'b0, sram_d_oe}, 32'd0);
        check("rst_adr", {10'b0, sram_adr}, 32'd0);
        check("rst_d_o", sram_d_o, 32'd0);
        check("rst_acks", {30'b0, m1_ack, m0_ack}, 32'd0);
        check("rst_rdata0", m0_rdata, 32'd0);
        check("rst_rdata1", m1_rdata, 32'd0);
        check("rst_busy", {31'b0, busy}, 32'd0);
        reset = 1'b0;

        // Test 1: m0 read of 0x000123, oe_n low exactly cycles 1-2, ack cycle 3
        m0_req = 1'b1; m0_we = 1'b0; m0_adr = 22'h000123;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk12);
            check("t1_oe_n", {31'b0, sram_oe_n}, (c <= 2) ? 32'd0 : 32'd1);
            check("t1_ack", {31'b0, m0_ack}, (c == 3) ? 32'd1 : 32'd0);
            check("t1_busy", {31'b0, busy}, 32'd1);
        end
        check("t1_rdata", m0_rdata, 32'hDEADBEEF);
        $display("t1 read adr=000123 rdata=%h", m0_rdata);
        m0_req = 1'b0;

        // Test 2: m1 write 0x3FFFFF, we_n low cycles 2-3, ce_n low at we_n rise, ack cycle 5
        @(negedge clk12);
        check("t2_ack_off", {31'b0, m0_ack}, 32'd0);
        check("t2_idle_busy", {31'b0, busy}, 32'd0);
        m1_req = 1'b1; m1_we = 1'b1; m1_adr = 22'h3FFFFF; m1_wdata = 32'hA5A55A5A; m1_be = 4'hF;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk12);
            check("t2_we_n", {31'b0, sram_we_n}, (c == 2 || c == 3) ? 32'd0 : 32'd1);
            check("t2_ce_n", {31'b0, sram_ce_n}, (c <= 4) ? 32'd0 : 32'd1);
            check("t2_d_oe", {31'b0, sram_d_oe}, (c <= 4) ? 32'd1 : 32'd0);
            check("t2_ack", {31'b0, m1_ack}, (c == 5) ? 32'd1 : 32'd0);
            if (c <= 4) check("t2_d_o", sram_d_o, 32'hA5A55A5A);
        end
        check("t2_rdata1_hold", m1_rdata, 32'd0);
        $display("t2 write adr=3fffff data=a5a55a5a");
        m1_req = 1'b0;
        do_access(0, 1'b0, 22'h3FFFFF, 32'h0, 4'h0, 0, "t2_rb");
        check("t2_rb_data", m0_rdata, 32'hA5A55A5A);

        // Test 3: simultaneous requests, round winners alternate 0,1,0,1
        for (int r = 0; r < 4; r++) begin
            @(negedge clk12);
            m0_req = 1'b1; m0_we = 1'b0; m0_adr = 22'h000010;
            m1_req = 1'b1; m1_we = 1'b0; m1_adr = 22'h000011;
            first = -1; n = 0;
            while (first < 0 && n < 20) begin
                @(negedge clk12);
                n++;
                if (m0_ack && m1_ack) first = 2;
                else if (m0_ack) first = 0;
                else if (m1_ack) first = 1;
            end
            check("t3_first", first, r % 2);
            check("t3_first_lat", n, 3);
            if (first == 0) m0_req = 1'b0;
            else if (first == 1) m1_req = 1'b0;
            else begin m0_req = 1'b0; m1_req = 1'b0; end
            second = -1;
            while (second < 0 && n < 30) begin
                @(negedge clk12);
                n++;
                if (m0_ack && m1_ack) second = 2;
                else if (m0_ack) second = 0;
                else if (m1_ack) second = 1;
            end
            check("t3_second", second, 1 - (r % 2));
            check("t3_second_lat", n, 7);
            m0_req = 1'b0; m1_req = 1'b0;
            check("t3_rdata0", m0_rdata, 32'h11111111);
            check("t3_rdata1", m1_rdata, 32'h22222222);
            $display("t3 round=%0d first=%0d second=%0d", r, first, second);
        end

        // Test 4: byte-enable write be=0101 over a cleared word
        do_access(0, 1'b1, 22'h000055, 32'h00000000, 4'hF, 0, "t4_clr");
        do_access(0, 1'b1, 22'h000055, 32'hFFFFFFFF, 4'b0101, 0, "t4_bw");
        do_access(0, 1'b0, 22'h000055, 32'h0, 4'h0, 0, "t4_rb");
        check("t4_rb_data", m0_rdata, 32'h00FF00FF);

        // Test 5: 16 idle cycles enter sleep; a read wakes it with 5 extra cycles
        for (int i = 1; i <= 17; i++) begin
            @(negedge clk12);
            if (i == 16) check("t5_zz_before", {31'b0, sram_zz_n}, 32'd1);
            if (i == 17) begin
                check("t5_zz_sleep", {31'b0, sram_zz_n}, 32'd0);
                check("t5_busy_sleep", {31'b0, busy}, 32'd0);
            end
        end
        repeat (3) @(negedge clk12);
        check("t5_zz_stay", {31'b0, sram_zz_n}, 32'd0);
        $display("t5 sleep entered zz_n=%0d", sram_zz_n);
        do_access(0, 1'b0, 22'h000123, 32'h0, 4'h0, 5, "t5_wake");
        check("t5_rdata", m0_rdata, 32'hDEADBEEF);

        // Test 6: reset during WR_PULSE releases strobes immediately, no ack
        @(negedge clk12);
        m1_req = 1'b1; m1_we = 1'b1; m1_adr = 22'h000077; m1_wdata = 32'h12345678; m1_be = 4'hF;
        @(negedge clk12);
        @(negedge clk12);
        check("t6_in_pulse", {31'b0, sram_we_n}, 32'd0);
        #2;
        reset = 1'b1;
        m1_req = 1'b0;
        #1;
        check("t6_ce_n", {31'b0, sram_ce_n}, 32'd1);
        check("t6_we_n", {31'b0, sram_we_n}, 32'd1);
        check("t6_d_oe", {31'b0, sram_d_oe}, 32'd0);
        check("t6_dm_n", {28'b0, sram_dm_n}, 32'hF);
        check("t6_rdata0", m0_rdata, 32'd0);
        check("t6_busy", {31'b0, busy}, 32'd0);
        $display("t6 reset mid-write ce_n=%0d we_n=%0d", sram_ce_n, sram_we_n);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk12);
            check("t6_no_ack", {30'b0, m1_ack, m0_ack}, 32'd0);
        end
        reset = 1'b0;
        do_access(0, 1'b0, 22'h000123, 32'h0, 4'h0, 0, "t6_rd0");
        check("t6_rd0_data", m0_rdata, 32'hDEADBEEF);
        do_access(1, 1'b0, 22'h3FFFFF, 32'h0, 4'h0, 0, "t6_rd1");
        check("t6_rd1_data", m1_rdata, 32'hA5A55A5A);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
